// File: rtl/adat_tx.sv
// adat_tx -- ADAT lightpipe transmitter.
//
// Accepts whole audio frames over a valid/ready handshake into a one-deep
// holding register and serialises them as 256-bit NRZI-encoded ADAT frames.
// One ADAT bit is emitted per ce strobe.
//
// Parameters:
//   SAMPLE_W  sample width 1..24, left-justified into the 24-bit slot
//   CHANNELS  populated channels 1..8, remaining slots carry zero
//
// Ports:
//   clk            system clock (>= 12.288 MHz)
//   rst            synchronous active-high reset
//   ce             bit strobe, one pulse per ADAT bit
//   frame_valid    frame offered on frame_data/frame_user
//   frame_ready    holding register empty (registered)
//   frame_data     CHANNELS*SAMPLE_W signed samples, channel c at [c*SAMPLE_W +: SAMPLE_W]
//   frame_user     {timecode, midi, smux}
//   adat_bitstream NRZI line output
//   frame_start    pulse in the clk where bit 0 of a frame appears on the line
//   underrun       pulse with frame_start when no frame was held at load time
//
// Build option:
//   ADAT_TX_MUTE_ON_UNDERRUN_EN  when defined, an underrun frame carries zero
//   audio and user bits; otherwise the last transmitted frame is repeated.

module adat_tx #(
  parameter int SAMPLE_W = 24,
  parameter int CHANNELS = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ce,
  input  logic                         frame_valid,
  output logic                         frame_ready,
  input  logic [CHANNELS*SAMPLE_W-1:0] frame_data,
  input  logic [2:0]                   frame_user,
  output logic                         adat_bitstream,
  output logic                         frame_start,
  output logic                         underrun
);

  localparam int DATA_W = CHANNELS * SAMPLE_W;

  logic [DATA_W-1:0] hold_data_q;
  logic [2:0]        hold_user_q;
  logic              hold_full_q, hold_full_d;
  logic              ready_q;
  logic [7:0]        cnt_q;
  // Audio/user of the frame on the line; doubles as the repeat buffer.
  logic [191:0]      slots_q;
  logic [2:0]        user_q;
  logic              line_q, start_q, underrun_q;

  logic [191:0]      hold_slots;
  logic [255:0]      raw;
  logic              load, handshake;

  assign load      = ce && (cnt_q == 8'd0);
  assign handshake = frame_valid && ready_q;

  // Left-justify each held sample into its 24-bit slot; empty slots are zero.
  for (genvar gi = 0; gi < 8; gi++) begin : g_slot
    if (gi < CHANNELS) begin : g_pop
      if (SAMPLE_W == 24) begin : g_full
        assign hold_slots[gi*24 +: 24] = hold_data_q[gi*SAMPLE_W +: SAMPLE_W];
      end else begin : g_pad
        assign hold_slots[gi*24 +: 24] =
          {hold_data_q[gi*SAMPLE_W +: SAMPLE_W], {(24-SAMPLE_W){1'b0}}};
      end
    end else begin : g_empty
      assign hold_slots[gi*24 +: 24] = 24'd0;
    end
  end

  // Raw frame image indexed by bit position. Bit 0 is always 1, so the
  // load cycle can emit it before slots_q holds the new frame.
  assign raw[0]     = 1'b1;
  assign raw[10:1]  = 10'd0;
  assign raw[11]    = 1'b1;
  assign raw[12]    = user_q[2];
  assign raw[13]    = user_q[1];
  assign raw[14]    = user_q[0];
  assign raw[15]    = 1'b0;

  // 48 nibble groups (8 channels x 6 nibbles, MSB nibble first), each a
  // sync 1 followed by the nibble MSB-first.
  for (genvar gi = 0; gi < 48; gi++) begin : g_nib
    localparam int CH  = gi / 6;
    localparam int NIB = gi % 6;
    assign raw[16 + gi*5] = 1'b1;
    for (genvar bj = 0; bj < 4; bj++) begin : g_bit
      assign raw[16 + gi*5 + 1 + bj] = slots_q[CH*24 + 23 - NIB*4 - bj];
    end
  end

  // A handshake can only happen while the register is empty, so it never
  // collides with a load consuming held data.
  always_comb begin
    hold_full_d = hold_full_q;
    if (load)      hold_full_d = 1'b0;
    if (handshake) hold_full_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_data_q <= '0;
      hold_user_q <= '0;
      hold_full_q <= 1'b0;
      ready_q     <= 1'b1;
      cnt_q       <= 8'd0;
      slots_q     <= '0;
      user_q      <= '0;
      line_q      <= 1'b0;
      start_q     <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      hold_full_q <= hold_full_d;
      ready_q     <= ~hold_full_d;
      if (handshake) begin
        hold_data_q <= frame_data;
        hold_user_q <= frame_user;
      end
      start_q    <= load;
      underrun_q <= load && !hold_full_q;
      if (ce) begin
        line_q <= line_q ^ raw[cnt_q];
        cnt_q  <= cnt_q + 8'd1;
      end
      if (load) begin
        if (hold_full_q) begin
          slots_q <= hold_slots;
          user_q  <= hold_user_q;
        end
`ifdef ADAT_TX_MUTE_ON_UNDERRUN_EN
        else begin
          slots_q <= '0;
          user_q  <= '0;
        end
`endif
      end
    end
  end

  assign frame_ready    = ready_q;
  assign adat_bitstream = line_q;
  assign frame_start    = start_q;
  assign underrun       = underrun_q;

endmodule

// File: tb/tb_adat_tx.sv
module tb_adat_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         ce;
  logic         frame_valid = 1'b0;
  logic         frame_ready;
  logic [191:0] frame_data = '0;
  logic [2:0]   frame_user = '0;
  logic         adat_bitstream, frame_start, underrun;

  logic         ce2 = 1'b1;
  logic         frame_valid2 = 1'b0;
  logic         frame_ready2;
  logic [31:0]  frame_data2 = '0;
  logic [2:0]   frame_user2 = '0;
  logic         adat2, fs2, uf2;

  adat_tx #(.SAMPLE_W(24), .CHANNELS(8)) dut (
    .clk(clk), .rst(rst), .ce(ce), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .frame_data(frame_data), .frame_user(frame_user),
    .adat_bitstream(adat_bitstream), .frame_start(frame_start), .underrun(underrun)
  );

  adat_tx #(.SAMPLE_W(16), .CHANNELS(2)) dut2 (
    .clk(clk), .rst(rst), .ce(ce2), .frame_valid(frame_valid2),
    .frame_ready(frame_ready2), .frame_data(frame_data2), .frame_user(frame_user2),
    .adat_bitstream(adat2), .frame_start(fs2), .underrun(uf2)
  );

  // Bit strobe: every clk, or every 4th clk when ce_div4 is set.
  logic ce_div4 = 1'b0;
  int   ce_phase = 0;
  initial begin
    ce = 1'b1;
    forever begin
      @(negedge clk);
      ce_phase = (ce_phase + 1) % 4;
      ce = ce_div4 ? (ce_phase == 0) : 1'b1;
    end
  end

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [29:0]  Z30  = {6{5'b10000}};
  localparam logic [179:0] ZMID = {36{5'b10000}};
  localparam logic [11:0]  HDR  = 12'b1000_0000_0001;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Bits r[lo .. lo+len-1], r[lo] ending up as the most significant.
  function automatic logic [255:0] seg(input logic [255:0] r, input int lo, input int len);
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < len; i++) v = {v[254:0], r[lo + i]};
    return v;
  endfunction

  function automatic logic line_of(input int sel);
    return (sel == 2) ? adat2 : adat_bitstream;
  endfunction
  function automatic logic fs_of(input int sel);
    return (sel == 2) ? fs2 : frame_start;
  endfunction
  function automatic logic uf_of(input int sel);
    return (sel == 2) ? uf2 : underrun;
  endfunction

  // Call at a negedge with ce=1 every clk. Waits for the next frame_start
  // and decodes the 256 raw bits from consecutive NRZI line samples.
  task automatic capture(input int sel, output logic [255:0] raw, output logic uf, output int gap);
    logic prev;
    int   n;
    n   = 0;
    raw = '0;
    uf  = 1'b0;
    prev = line_of(sel);
    @(negedge clk);
    while (!fs_of(sel) && n < 3000) begin
      prev = line_of(sel);
      @(negedge clk);
      n++;
    end
    gap = n;
    if (!fs_of(sel)) begin
      n_cmp++;
      n_fail++;
      $display("FAIL capture_timeout: actual no frame_start required frame_start");
      return;
    end
    uf = uf_of(sel);
    raw[0] = line_of(sel) ^ prev;
    for (int i = 1; i < 256; i++) begin
      prev = line_of(sel);
      @(negedge clk);
      raw[i] = line_of(sel) ^ prev;
    end
  endtask

  task automatic offer1(input logic [23:0] c0, input logic [23:0] c7, input logic [2:0] u);
    int n;
    n = 0;
    repeat (20) @(negedge clk);
    frame_data          = '0;
    frame_data[23:0]    = c0;
    frame_data[191:168] = c7;
    frame_user          = u;
    frame_valid         = 1'b1;
    while (!frame_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    frame_valid = 1'b0;
    check("ready_low_after_accept", 256'(frame_ready), 256'(1'b0));
  endtask

  typedef struct {
    logic        offer;
    logic [23:0] ch0;
    logic [23:0] ch7;
    logic [2:0]  user;
    logic        uf;
    logic [3:0]  e_user;
    logic [29:0] e_ch0;
    logic [29:0] e_ch7;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] raw;
    logic         uf;
    int           gap, n, hs;
    logic         last_ready;

    tbl[0] = '{1'b0, 24'h0, 24'h0, 3'b000, 1'b1, 4'b0000, Z30, Z30};
    tbl[1] = '{1'b1, 24'h800001, 24'h0, 3'b101, 1'b0, 4'b1010,
               30'b11000_10000_10000_10000_10000_10001, Z30};
    tbl[2] = '{1'b1, 24'h123456, 24'hFEDCBA, 3'b010, 1'b0, 4'b0100,
               30'b10001_10010_10011_10100_10101_10110,
               30'b11111_11110_11101_11100_11011_11010};
    tbl[3] = '{1'b1, 24'hFFFFFF, 24'h7FFFFF, 3'b111, 1'b0, 4'b1110,
               30'b11111_11111_11111_11111_11111_11111,
               30'b10111_11111_11111_11111_11111_11111};
`ifdef ADAT_TX_MUTE_ON_UNDERRUN_EN
    tbl[4] = '{1'b0, 24'h0, 24'h0, 3'b000, 1'b1, 4'b0000, Z30, Z30};
`else
    tbl[4] = '{1'b0, 24'h0, 24'h0, 3'b000, 1'b1, 4'b1110,
               30'b11111_11111_11111_11111_11111_11111,
               30'b10111_11111_11111_11111_11111_11111};
`endif
    tbl[5] = tbl[4];

    // Reset state.
    repeat (4) @(negedge clk);
    check("rst_line",   256'(adat_bitstream), 256'(1'b0));
    check("rst_ready",  256'(frame_ready),    256'(1'b1));
    check("rst_start",  256'(frame_start),    256'(1'b0));
    check("rst_uf",     256'(underrun),       256'(1'b0));
    check("rst_ready2", 256'(frame_ready2),   256'(1'b1));
    rst = 1'b0;

    // Table: frame r is captured while frame r+1 is offered.
    for (int r = 0; r < 6; r++) begin
      fork
        capture(1, raw, uf, gap);
        begin
          if (r + 1 < 6 && tbl[r+1].offer)
            offer1(tbl[r+1].ch0, tbl[r+1].ch7, tbl[r+1].user);
        end
      join
      $display("frame %0d: uf=%0b gap=%0d raw=%0h", r, uf, gap, raw);
      check($sformatf("v%0d_gap", r),  256'(gap), 256'(0));
      check($sformatf("v%0d_uf", r),   256'(uf), 256'(tbl[r].uf));
      check($sformatf("v%0d_hdr", r),  seg(raw, 0, 12), 256'(HDR));
      check($sformatf("v%0d_user", r), seg(raw, 12, 4), 256'(tbl[r].e_user));
      check($sformatf("v%0d_ch0", r),  seg(raw, 16, 30), 256'(tbl[r].e_ch0));
      check($sformatf("v%0d_mid", r),  seg(raw, 46, 180), 256'(ZMID));
      check($sformatf("v%0d_ch7", r),  seg(raw, 226, 30), 256'(tbl[r].e_ch7));
    end

    // SAMPLE_W=16, CHANNELS=2 instance: padding and empty slots.
    n = 0;
    while (!fs2 && n < 3000) begin @(negedge clk); n++; end
    frame_data2  = {16'hFFFF, 16'h8001};
    frame_user2  = 3'b000;
    frame_valid2 = 1'b1;
    n = 0;
    while (!frame_ready2 && n < 10) begin @(negedge clk); n++; end
    @(negedge clk);
    frame_valid2 = 1'b0;
    capture(2, raw, uf, gap);
    $display("dut2 frame: uf=%0b raw=%0h", uf, raw);
    check("n16_uf",   256'(uf), 256'(1'b0));
    check("n16_ch0",  seg(raw, 16, 30), 256'(30'b11000_10000_10000_10001_10000_10000));
    check("n16_ch1",  seg(raw, 46, 30), 256'(30'b11111_11111_11111_11111_10000_10000));
    check("n16_rest", seg(raw, 76, 180), 256'(ZMID));

    // Reset at cnt=100 with the holding register full, plus a handshake
    // attempt while rst is high.
    n = 0;
    while (!frame_start && n < 3000) begin @(negedge clk); n++; end
    fork
      offer1(24'h123456, 24'hFEDCBA, 3'b010);
      repeat (99) @(negedge clk);
    join
    check("hold_full_before_rst", 256'(frame_ready), 256'(1'b0));
    frame_data[23:0] = 24'h654321;
    frame_user       = 3'b111;
    rst              = 1'b1;
    frame_valid      = 1'b1;
    @(negedge clk);
    check("midrst_line",  256'(adat_bitstream), 256'(1'b0));
    check("midrst_ready", 256'(frame_ready),    256'(1'b1));
    @(negedge clk);
    rst         = 1'b0;
    frame_valid = 1'b0;
    capture(1, raw, uf, gap);
    $display("post-reset frame: uf=%0b gap=%0d raw=%0h", uf, gap, raw);
    check("postrst_gap",  256'(gap), 256'(0));
    check("postrst_uf",   256'(uf), 256'(1'b1));
    check("postrst_user", seg(raw, 12, 4), 256'(4'b0000));
    check("postrst_ch0",  seg(raw, 16, 30), 256'(Z30));
    check("postrst_ch7",  seg(raw, 226, 30), 256'(Z30));

    // ce every 4th clk with frames offered back-to-back.
    frame_data       = '0;
    frame_data[23:0] = 24'h123456;
    frame_user       = 3'b010;
    frame_valid      = 1'b1;
    ce_div4          = 1'b1;
    n = 0;
    while (!frame_start && n < 3000) begin @(negedge clk); n++; end
    for (int f = 0; f < 4; f++) begin
      n  = 0;
      hs = 0;
      last_ready = 1'b0;
      do begin
        if (frame_valid && frame_ready) hs++;
        last_ready = frame_ready;
        @(negedge clk);
        n++;
      end while (!frame_start && n < 3000);
      $display("div4 interval %0d: clks=%0d handshakes=%0d", f, n, hs);
      if (f >= 1) begin
        check($sformatf("div4_%0d_period", f),     256'(n), 256'(1024));
        check($sformatf("div4_%0d_handshakes", f), 256'(hs), 256'(1));
        check($sformatf("div4_%0d_ready_load", f), 256'(last_ready), 256'(1'b0));
        check($sformatf("div4_%0d_ready_after", f), 256'(frame_ready), 256'(1'b1));
        check($sformatf("div4_%0d_uf", f),         256'(underrun), 256'(1'b0));
      end
    end
    frame_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
